// File: rtl/cpu_main_control.sv
`default_nettype none
// ============================================================================
// Module   : cpu_main_control
// Purpose  : Multicycle Moore control FSM sequencing the CPU datapath
//            (R-type add/sub/and, addi, lw, sw, beq, bne, j, exceptions).
// Revision : 1.0
// ============================================================================
module cpu_main_control #(
  parameter int STACK_NONE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic [5:0] funct,
  input  logic       eqf,
  input  logic       ov,
  output logic       MemCtrl,
  output logic       PCCtrl,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUOutCtrl,
  output logic       EPCCtrl,
  output logic [1:0] IorD,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] RegDst,
  output logic [1:0] LSCtrl,
  output logic [1:0] SSCtrl,
  output logic [1:0] ExcptCtrl,
  output logic [2:0] PCSrc,
  output logic [2:0] ALUCtrl,
  output logic [3:0] DataSrc,
  output logic [4:0] state
);

  localparam logic [5:0] c_opRType = 6'h00;
  localparam logic [5:0] c_opAddi  = 6'h08;
  localparam logic [5:0] c_opLw    = 6'h23;
  localparam logic [5:0] c_opSw    = 6'h2B;
  localparam logic [5:0] c_opBeq   = 6'h04;
  localparam logic [5:0] c_opBne   = 6'h05;
  localparam logic [5:0] c_opJ     = 6'h02;
  localparam logic [5:0] c_fnAdd   = 6'h20;
  localparam logic [5:0] c_fnSub   = 6'h22;
  localparam logic [5:0] c_fnAnd   = 6'h24;

  localparam logic [2:0] c_aluAdd  = 3'b001;
  localparam logic [2:0] c_aluSub  = 3'b010;
  localparam logic [2:0] c_aluAnd  = 3'b011;
  localparam logic [2:0] c_aluCmp  = 3'b111;

  localparam logic [1:0] c_excInvalid  = 2'd0;
  localparam logic [1:0] c_excOverflow = 2'd1;

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_DECODE     = 5'd3,
    S_EXEC_R     = 5'd4,
    S_WB_R       = 5'd5,
    S_ADDI_EX    = 5'd6,
    S_ADDI_WB    = 5'd7,
    S_MEM_ADDR   = 5'd8,
    S_LW_RD      = 5'd9,
    S_LW_WAIT    = 5'd10,
    S_LW_WB      = 5'd11,
    S_SW_WR      = 5'd12,
    S_BRANCH     = 5'd13,
    S_JUMP       = 5'd14,
    S_EXC_EPC    = 5'd15,
    S_EXC_RD     = 5'd16,
    S_EXC_WAIT   = 5'd17,
    S_EXC_LD     = 5'd18
  } state_t;

  generate
    if (STACK_NONE != 0) begin : g_stackUnsupported
      $error("cpu_main_control: STACK_NONE must be 0");
    end
  endgenerate

  state_t     r_state;
  state_t     w_nextState;
  logic       r_ovFlag;
  logic [1:0] r_excCode;
  logic [1:0] w_excCodeNext;
  logic       w_fnValid;

  assign w_fnValid = (funct == c_fnAdd) || (funct == c_fnSub) || (funct == c_fnAnd);
  assign state     = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_RESET;
      r_ovFlag  <= 1'b0;
      r_excCode <= c_excInvalid;
    end else begin
      r_state   <= w_nextState;
      r_excCode <= w_excCodeNext;
      // Overflow is meaningless for the logical 'and', so it never raises the flag.
      if (r_state == S_EXEC_R)
        r_ovFlag <= ov && (funct != c_fnAnd);
      else if (r_state == S_ADDI_EX)
        r_ovFlag <= ov;
    end
  end

  always_comb begin
    w_nextState   = S_FETCH;
    w_excCodeNext = r_excCode;
    case (r_state)
      S_RESET:      w_nextState = S_FETCH;
      S_FETCH:      w_nextState = S_FETCH_WAIT;
      S_FETCH_WAIT: w_nextState = S_DECODE;
      S_DECODE: begin
        case (opCode)
          c_opRType: begin
            if (w_fnValid) begin
              w_nextState = S_EXEC_R;
            end else begin
              w_nextState   = S_EXC_EPC;
              w_excCodeNext = c_excInvalid;
            end
          end
          c_opAddi:        w_nextState = S_ADDI_EX;
          c_opLw, c_opSw:  w_nextState = S_MEM_ADDR;
          c_opBeq, c_opBne: w_nextState = S_BRANCH;
          c_opJ:           w_nextState = S_JUMP;
          default: begin
            w_nextState   = S_EXC_EPC;
            w_excCodeNext = c_excInvalid;
          end
        endcase
      end
      S_EXEC_R:  w_nextState = S_WB_R;
      S_ADDI_EX: w_nextState = S_ADDI_WB;
      S_WB_R, S_ADDI_WB: begin
        if (r_ovFlag) begin
          w_nextState   = S_EXC_EPC;
          w_excCodeNext = c_excOverflow;
        end
      end
      S_MEM_ADDR: w_nextState = (opCode == c_opSw) ? S_SW_WR : S_LW_RD;
      S_LW_RD:    w_nextState = S_LW_WAIT;
      S_LW_WAIT:  w_nextState = S_LW_WB;
      S_EXC_EPC:  w_nextState = S_EXC_RD;
      S_EXC_RD:   w_nextState = S_EXC_WAIT;
      S_EXC_WAIT: w_nextState = S_EXC_LD;
      default:    w_nextState = S_FETCH;
    endcase
  end

  always_comb begin
    MemCtrl    = 1'b0;
    PCCtrl     = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUOutCtrl = 1'b0;
    EPCCtrl    = 1'b0;
    IorD       = 2'd0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    RegDst     = 2'd0;
    LSCtrl     = 2'd0;
    SSCtrl     = 2'd0;
    ExcptCtrl  = 2'd0;
    PCSrc      = 3'd0;
    ALUCtrl    = 3'd0;
    DataSrc    = 4'd0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB = 2'd1;
        ALUCtrl = c_aluAdd;
        PCCtrl  = 1'b1;
      end
      S_FETCH_WAIT: IRWrite = 1'b1;
      S_DECODE: begin
        ALUSrcB    = 2'd3;
        ALUCtrl    = c_aluAdd;
        ALUOutCtrl = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA    = 2'd1;
        ALUOutCtrl = 1'b1;
        case (funct)
          c_fnSub: ALUCtrl = c_aluSub;
          c_fnAnd: ALUCtrl = c_aluAnd;
          default: ALUCtrl = c_aluAdd;
        endcase
      end
      S_WB_R, S_ADDI_WB: begin
        if (!r_ovFlag) begin
          RegDst   = (r_state == S_WB_R) ? 2'd1 : 2'd0;
          RegWrite = 1'b1;
        end
      end
      S_ADDI_EX, S_MEM_ADDR: begin
        ALUSrcA    = 2'd1;
        ALUSrcB    = 2'd2;
        ALUCtrl    = c_aluAdd;
        ALUOutCtrl = 1'b1;
      end
      S_LW_RD, S_LW_WAIT: IorD = 2'd2;
      S_LW_WB: begin
        DataSrc  = 4'd1;
        RegWrite = 1'b1;
      end
      S_SW_WR: begin
        IorD    = 2'd2;
        MemCtrl = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'd1;
        ALUCtrl = c_aluCmp;
        PCSrc   = 3'd1;
        PCCtrl  = (opCode == c_opBeq) ? eqf : ~eqf;
      end
      S_JUMP: begin
        PCSrc  = 3'd2;
        PCCtrl = 1'b1;
      end
      S_EXC_EPC: begin
        ALUSrcB   = 2'd1;
        ALUCtrl   = c_aluSub;
        EPCCtrl   = 1'b1;
        ExcptCtrl = r_excCode;
      end
      S_EXC_RD, S_EXC_WAIT: begin
        IorD      = 2'd3;
        ExcptCtrl = r_excCode;
      end
      S_EXC_LD: begin
        LSCtrl    = 2'd2;
        PCSrc     = 3'd3;
        PCCtrl    = 1'b1;
        ExcptCtrl = r_excCode;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_main_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_main_control
// Purpose  : Closes cpu_main_control around a small behavioural datapath and
//            scoreboards the state sequence plus architectural results.
// Revision : 1.0
// ============================================================================
module tb_cpu_main_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opCode, funct;
  logic       eqf, ov;
  logic       MemCtrl, PCCtrl, IRWrite, RegWrite, ALUOutCtrl, EPCCtrl;
  logic [1:0] IorD, ALUSrcA, ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl;
  logic [2:0] PCSrc, ALUCtrl;
  logic [3:0] DataSrc;
  logic [4:0] state;

  cpu_main_control #(.STACK_NONE(0)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .funct(funct), .eqf(eqf), .ov(ov),
    .MemCtrl(MemCtrl), .PCCtrl(PCCtrl), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ALUOutCtrl(ALUOutCtrl), .EPCCtrl(EPCCtrl), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .RegDst(RegDst), .LSCtrl(LSCtrl), .SSCtrl(SSCtrl),
    .ExcptCtrl(ExcptCtrl), .PCSrc(PCSrc), .ALUCtrl(ALUCtrl), .DataSrc(DataSrc),
    .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural datapath; registers update at the falling edge using the
  // control word that is stable for the current state.
  logic [31:0] pc, ir, mdr, regA, regB, aluOut, epc;
  logic [31:0] rf [32];
  logic [7:0]  mem [512];
  logic [31:0] srcA, srcB, aluRes, memAddr, loadOut, seImm;
  logic [29:0] allOut;

  assign opCode = ir[31:26];
  assign funct  = ir[5:0];
  assign allOut = {MemCtrl, PCCtrl, IRWrite, RegWrite, ALUOutCtrl, EPCCtrl, IorD, ALUSrcA,
                   ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl, PCSrc, ALUCtrl, DataSrc};

  always_comb begin
    seImm  = {{16{ir[15]}}, ir[15:0]};
    srcA   = (ALUSrcA == 2'd1) ? regA : pc;
    case (ALUSrcB)
      2'd0:    srcB = regB;
      2'd1:    srcB = 32'd4;
      2'd2:    srcB = seImm;
      default: srcB = seImm << 2;
    endcase
    aluRes = 32'd0;
    ov     = 1'b0;
    case (ALUCtrl)
      3'b001: begin
        aluRes = srcA + srcB;
        ov = (srcA[31] == srcB[31]) && (aluRes[31] != srcA[31]);
      end
      3'b010, 3'b111: begin
        aluRes = srcA - srcB;
        ov = (srcA[31] != srcB[31]) && (aluRes[31] != srcA[31]);
      end
      3'b011:  aluRes = srcA & srcB;
      default: ;
    endcase
    eqf = (srcA == srcB);
    case (IorD)
      2'd0:    memAddr = pc;
      2'd1:    memAddr = aluRes;
      2'd2:    memAddr = aluOut;
      default: memAddr = (ExcptCtrl == 2'd0) ? 32'd253 : 32'd254;
    endcase
    loadOut = (LSCtrl == 2'd2) ? {24'd0, mdr[31:24]} : mdr;
  end

  function automatic logic [31:0] memRd(input logic [31:0] a);
    logic [8:0] b;
    b = a[8:0];
    return {mem[b], mem[b + 9'd1], mem[b + 9'd2], mem[b + 9'd3]};
  endfunction

  task automatic memWr(input logic [31:0] a, input logic [31:0] d);
    logic [8:0] b;
    b = a[8:0];
    {mem[b], mem[b + 9'd1], mem[b + 9'd2], mem[b + 9'd3]} = d;
  endtask

  task automatic stepDatapath();
    logic [31:0] res, rdWord, ld, nA, nB, jt, wa;
    logic [4:0]  dst;
    res    = aluRes;
    wa     = memAddr;
    rdWord = memRd(memAddr);
    ld     = loadOut;
    nA     = rf[ir[25:21]];
    nB     = rf[ir[20:16]];
    jt     = {pc[31:28], ir[25:0], 2'b00};
    if (MemCtrl) memWr(wa, regB);
    if (RegWrite) begin
      dst = (RegDst == 2'd1) ? ir[15:11] : ir[20:16];
      if (dst != 5'd0) rf[dst] = (DataSrc == 4'd0) ? aluOut : ld;
    end
    if (PCCtrl) begin
      case (PCSrc)
        3'd0:    pc = res;
        3'd1:    pc = aluOut;
        3'd2:    pc = jt;
        3'd3:    pc = ld;
        default: pc = epc;
      endcase
    end
    if (IRWrite)    ir = mdr;
    if (ALUOutCtrl) aluOut = res;
    if (EPCCtrl)    epc = res;
    regA = nA;
    regB = nB;
    mdr  = rdWord;
  endtask

  int vecCnt = 0;
  int errCnt = 0;
  int expQ[$];
  int memWrCnt, regWrCnt;
  logic [1:0] excExp;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic resetDp(input logic [31:0] pcStart);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = 8'd0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    pc = pcStart; ir = 32'd0; mdr = 32'd0; regA = 32'd0; regB = 32'd0;
    aluOut = 32'd0; epc = 32'd0;
    memWrCnt = 0; regWrCnt = 0; excExp = 2'd0;
    expQ.delete();
  endtask

  // Pops one expected state per cycle; the final entry is checked but not executed.
  task automatic releaseAndRun();
    int exp;
    @(negedge clk);
    reset = 1'b0;
    while (expQ.size() > 0) begin
      @(negedge clk);
      exp = expQ.pop_front();
      checkVal("state", 32'(state), 32'(exp));
      checkVal("memctrl_regwrite_excl", 32'(MemCtrl & RegWrite), 32'd0);
      if (MemCtrl) begin
        memWrCnt++;
        checkVal("memctrl_state", 32'(state), 32'd12);
      end
      if (RegWrite) regWrCnt++;
      if (state >= 5'd15 && state <= 5'd18) checkVal("excptctrl", 32'(ExcptCtrl), 32'(excExp));
      if (state == 5'd16 || state == 5'd17) checkVal("iord_exc", 32'(IorD), 32'd3);
      if (expQ.size() > 0) stepDatapath();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    resetDp(32'd0);
    repeat (3) @(negedge clk);
    checkVal("reset_state", 32'(state), 32'd0);
    checkVal("reset_outputs", 32'(allOut), 32'd0);

    // Reset asserted in EXEC_R, then released
    resetDp(32'd0);
    memWr(32'd0, 32'h00221820);
    rf[1] = 32'd5; rf[2] = 32'd7;
    expQ = {1, 2, 3, 4};
    releaseAndRun();
    reset = 1'b1;
    #1;
    checkVal("rst_async_state", 32'(state), 32'd0);
    checkVal("rst_async_outputs", 32'(allOut), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkVal("rst_release_state", 32'(state), 32'd0);
    @(negedge clk);
    checkVal("rst_restart_fetch", 32'(state), 32'd1);
    checkVal("rst_no_writeback", rf[3], 32'd0);
    checkVal("rst_regwrite_count", 32'(regWrCnt), 32'd0);

    // add $3,$1,$2
    resetDp(32'd0);
    memWr(32'd0, 32'h00221820);
    rf[1] = 32'd5; rf[2] = 32'd7;
    expQ = {1, 2, 3, 4, 5, 1};
    releaseAndRun();
    checkVal("add_result", rf[3], 32'd12);
    checkVal("add_pc", pc, 32'd4);

    // sw $2,0x40($0) ; lw $4,0x40($0)
    resetDp(32'd0);
    memWr(32'd0, 32'hAC020040);
    memWr(32'd4, 32'h8C040040);
    rf[2] = 32'hDEADBEEF;
    expQ = {1, 2, 3, 8, 12, 1, 2, 3, 8, 9, 10, 11, 1};
    releaseAndRun();
    checkVal("sw_pulses", 32'(memWrCnt), 32'd1);
    checkVal("sw_mem", memRd(32'h40), 32'hDEADBEEF);
    checkVal("lw_result", rf[4], 32'hDEADBEEF);
    checkVal("lsw_pc", pc, 32'd8);

    // beq taken at 0 -> 16, bne not taken at 16 -> 20; word 4 traps a wrong path
    resetDp(32'd0);
    memWr(32'd0, 32'h10220003);
    memWr(32'd4, 32'hFC000000);
    memWr(32'd16, 32'h14220003);
    rf[1] = 32'd9; rf[2] = 32'd9;
    expQ = {1, 2, 3, 13, 1, 2, 3, 13, 1};
    releaseAndRun();
    checkVal("branch_pc", pc, 32'd20);

    // addi without overflow, then j 0x20
    resetDp(32'd0);
    memWr(32'd0, 32'h20210001);
    memWr(32'd4, 32'h08000008);
    rf[1] = 32'd1;
    expQ = {1, 2, 3, 6, 7, 1, 2, 3, 14, 1};
    releaseAndRun();
    checkVal("addi_result", rf[1], 32'd2);
    checkVal("jump_pc", pc, 32'h20);

    // addi overflow at 8 -> exception vector 254
    resetDp(32'd8);
    memWr(32'd8, 32'h20210001);
    mem[253] = 8'h80; mem[254] = 8'h84;
    rf[1] = 32'h7FFFFFFF;
    excExp = 2'd1;
    expQ = {1, 2, 3, 6, 7, 15, 16, 17, 18, 1};
    releaseAndRun();
    checkVal("ovf_reg_kept", rf[1], 32'h7FFFFFFF);
    checkVal("ovf_regwrite_count", 32'(regWrCnt), 32'd0);
    checkVal("ovf_epc", epc, 32'd8);
    checkVal("ovf_pc", pc, 32'h84);

    // invalid opcode at 0x0C -> exception vector 253
    resetDp(32'h0C);
    memWr(32'h0C, 32'hFC000000);
    mem[253] = 8'h80; mem[254] = 8'h84;
    excExp = 2'd0;
    expQ = {1, 2, 3, 15, 16, 17, 18, 1};
    releaseAndRun();
    checkVal("inv_epc", epc, 32'h0C);
    checkVal("inv_pc", pc, 32'h80);

    // sub, and, then unknown funct under opCode 0
    resetDp(32'd0);
    memWr(32'd0, 32'h00222822);
    memWr(32'd4, 32'h00223024);
    memWr(32'd8, 32'h00223821);
    mem[253] = 8'h80; mem[254] = 8'h84;
    rf[1] = 32'd12; rf[2] = 32'd10;
    excExp = 2'd0;
    expQ = {1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2, 3, 15, 16, 17, 18, 1};
    releaseAndRun();
    checkVal("sub_result", rf[5], 32'd2);
    checkVal("and_result", rf[6], 32'd8);
    checkVal("badfunct_no_write", rf[7], 32'd0);
    checkVal("badfunct_epc", epc, 32'd8);
    checkVal("badfunct_pc", pc, 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
`default_nettype wire
